// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit accumulator core:
//   opcode_t  - 3-bit opcode field instr[7:5]
//   alu_op_t  - ALU function select (cntr_alu)
//   ctrl_t    - bundle of every decode strobe produced by acc_decode
//   sign_ext_imm - widens the 5-bit immediate to the 8-bit datapath
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int IMM_W  = 5;

    typedef enum logic [2:0] {
        OP_LI  = 3'b000,
        OP_LA  = 3'b001,
        OP_MV  = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100,
        OP_JR  = 3'b101,
        OP_LW  = 3'b110,
        OP_SW  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef struct packed {
        alu_op_t cntr_alu;  // ALU function
        logic    alu_sc;    // operand B: 1 = reg_data, 0 = zero
        logic    acc_we;    // accumulator write enable
        logic    acc_sc;    // accumulator source: 1 = ext_imm, 0 = reg_data
        logic    reg_we;    // register file write enable
        logic    mem_we;    // data memory write enable
        logic    brnch;     // PC loads reg_data
        logic    lw;        // register write data from memory
        logic    mem_sc;    // memory address is the accumulator
    } ctrl_t;

    function automatic logic [DATA_W-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/acc_alu_ctrl_if.sv
// ---------------------------------------------------------------------------
// acc_alu_ctrl_if
// Signal bundle between the accumulator core and its surroundings
// (instruction register, register file, PC and data memory).
//   master : surroundings - drive instr / reg_data, observe strobes
//   slave  : the core     - consume instr / reg_data, drive strobes
// ---------------------------------------------------------------------------
interface acc_alu_ctrl_if;

    logic [7:0] instr;
    logic [7:0] reg_data;
    logic [4:0] reg_sel;
    logic [7:0] acc_out;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       alu_carry;
    logic       regWE;
    logic       memWE;
    logic       brnch;
    logic       lw;
    logic       mem_sc;

    modport master (
        output instr, reg_data,
        input  reg_sel, acc_out, alu_out, alu_zero, alu_carry,
        input  regWE, memWE, brnch, lw, mem_sc
    );

    modport slave (
        input  instr, reg_data,
        output reg_sel, acc_out, alu_out, alu_zero, alu_carry,
        output regWE, memWE, brnch, lw, mem_sc
    );

endinterface

// File: rtl/acc_alu.sv
// ---------------------------------------------------------------------------
// acc_alu
// Combinational 8-bit ALU, results modulo 256.
//   op    in  : ADD / SUB (a - b) / AND / OR
//   a, b  in  : operands
//   y     out : result
//   zero  out : y == 0
//   carry out : ADD carry out of bit 7; SUB no-borrow (a >= b); logic ops 0
// ---------------------------------------------------------------------------
module acc_alu
    import cpu_pkg::*;
(
    input  alu_op_t    op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic       zero,
    output logic       carry
);

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            ALU_ADD: {carry, y} = {1'b0, a} + {1'b0, b};
            ALU_SUB: begin
                y     = a - b;
                carry = (a >= b);
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: ;
        endcase
    end

    assign zero = (y == 8'h00);

endmodule

// File: rtl/acc_decode.sv
// ---------------------------------------------------------------------------
// acc_decode
// Combinational instruction decoder.
//   instr [7:0] in  : opcode = instr[7:5]
//   ctrl  ctrl_t out: all datapath strobes; anything an opcode does not use is 0
// ---------------------------------------------------------------------------
module acc_decode
    import cpu_pkg::*;
(
    input  logic [7:0] instr,
    output ctrl_t      ctrl
);

    opcode_t opcode;
    assign opcode = opcode_t'(instr[7:5]);

    always_comb begin
        // Non-ALU opcodes fall through as ADD with B = 0 so alu_out mirrors acc.
        ctrl          = '0;
        ctrl.cntr_alu = ALU_ADD;
        case (opcode)
            OP_LI: begin
                ctrl.acc_we = 1'b1;
                ctrl.acc_sc = 1'b1;
            end
            OP_LA: begin
                ctrl.acc_we = 1'b1;
            end
            OP_MV: begin
                ctrl.reg_we = 1'b1;
            end
            OP_ADD: begin
                ctrl.reg_we = 1'b1;
                ctrl.alu_sc = 1'b1;
            end
            OP_SUB: begin
                ctrl.reg_we   = 1'b1;
                ctrl.alu_sc   = 1'b1;
                ctrl.cntr_alu = ALU_SUB;
            end
            OP_JR: begin
                ctrl.brnch = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_we = 1'b1;
                ctrl.lw     = 1'b1;
                ctrl.mem_sc = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_we = 1'b1;
                ctrl.mem_sc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_alu_ctrl.sv
// ---------------------------------------------------------------------------
// acc_alu_ctrl
// Accumulator-centred execution core: decode, accumulator register, operand
// muxes, sign extension and ALU. One instruction per cycle, no handshake.
//   clk   in : rising-edge clock
//   reset in : synchronous, active-high; clears acc and masks write/branch strobes
//   bus   slave modport of acc_alu_ctrl_if:
//         instr, reg_data in; reg_sel, acc_out, alu_out, alu_zero, alu_carry,
//         regWE, memWE, brnch, lw, mem_sc out
// ---------------------------------------------------------------------------
module acc_alu_ctrl
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    acc_alu_ctrl_if.slave  bus
);

    ctrl_t       dec_ctrl;
    ctrl_t       ctrl;
    logic [7:0]  ext_imm;
    logic [7:0]  acc_next;
    logic [7:0]  acc_reg;
    logic [7:0]  alu_b;
    logic [7:0]  alu_y;
    logic        alu_z;
    logic        alu_c;

    acc_decode u_decode (
        .instr (bus.instr),
        .ctrl  (dec_ctrl)
    );

    // Reset masks every strobe that changes architectural state. lw and
    // mem_sc keep decoding: they only steer muxes and are harmless alone.
    always_comb begin
        ctrl = dec_ctrl;
        if (reset) begin
            ctrl.reg_we = 1'b0;
            ctrl.mem_we = 1'b0;
            ctrl.brnch  = 1'b0;
            ctrl.acc_we = 1'b0;
        end
    end

    assign ext_imm  = sign_ext_imm(bus.instr[4:0]);
    assign acc_next = ctrl.acc_sc ? ext_imm : bus.reg_data;
    assign alu_b    = ctrl.alu_sc ? bus.reg_data : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= 8'h00;
        end else if (ctrl.acc_we) begin
            acc_reg <= acc_next;
        end
    end

    acc_alu u_alu (
        .op    (ctrl.cntr_alu),
        .a     (acc_reg),
        .b     (alu_b),
        .y     (alu_y),
        .zero  (alu_z),
        .carry (alu_c)
    );

    assign bus.reg_sel   = bus.instr[4:0];
    assign bus.acc_out   = acc_reg;
    assign bus.alu_out   = alu_y;
    assign bus.alu_zero  = alu_z;
    assign bus.alu_carry = alu_c;
    assign bus.regWE     = ctrl.reg_we;
    assign bus.memWE     = ctrl.mem_we;
    assign bus.brnch     = ctrl.brnch;
    assign bus.lw        = ctrl.lw;
    assign bus.mem_sc    = ctrl.mem_sc;

endmodule

// File: tb/tb_acc_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_acc_alu_ctrl
// Directed bench for acc_alu_ctrl. Each step drives one instruction, pushes
// the predicted outputs to a queue, then pops and compares at the falling
// edge. A reference accumulator is advanced at the rising edge.
// ---------------------------------------------------------------------------
module tb_acc_alu_ctrl;

    typedef struct {
        logic [7:0] acc;
        logic [7:0] alu;
        logic       zero;
        logic       carry;
        logic [4:0] sel;
        logic       regwe;
        logic       memwe;
        logic       brnch;
        logic       lw;
        logic       mem_sc;
    } exp_t;

    logic clk;
    logic reset;
    acc_alu_ctrl_if bus();

    acc_alu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t       sb_q[$];
    logic [7:0] model_acc;
    int         n_assert;
    int         n_fail;

    function automatic exp_t predict(input logic [7:0] ins, input logic [7:0] rd,
                                     input logic rst, input logic [7:0] acc);
        exp_t       e;
        logic [2:0] op;
        logic [7:0] b;
        logic [8:0] wide;
        op       = ins[7:5];
        b        = (op == 3'd3 || op == 3'd4) ? rd : 8'h00;
        e.acc    = acc;
        if (op == 3'd4) begin
            e.alu   = acc - b;
            e.carry = (acc >= b);
        end else begin
            wide    = {1'b0, acc} + {1'b0, b};
            e.alu   = wide[7:0];
            e.carry = wide[8];
        end
        e.zero   = (e.alu == 8'h00);
        e.sel    = ins[4:0];
        e.regwe  = !rst && (op == 3'd2 || op == 3'd3 || op == 3'd4 || op == 3'd6);
        e.memwe  = !rst && (op == 3'd7);
        e.brnch  = !rst && (op == 3'd5);
        e.lw     = (op == 3'd6);
        e.mem_sc = (op == 3'd6 || op == 3'd7);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One instruction: drive, predict, compare at negedge, then clock it in.
    task automatic step(input logic [7:0] ins, input logic [7:0] rd,
                        input logic rst, input string tag);
        exp_t e;
        bus.instr    = ins;
        bus.reg_data = rd;
        reset        = rst;
        sb_q.push_back(predict(ins, rd, rst, model_acc));
        @(negedge clk);
        n_assert++;
        assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, ".acc"},    bus.acc_out,          e.acc);
            chk({tag, ".alu"},    bus.alu_out,          e.alu);
            chk({tag, ".zero"},   {7'd0, bus.alu_zero}, {7'd0, e.zero});
            chk({tag, ".carry"},  {7'd0, bus.alu_carry},{7'd0, e.carry});
            chk({tag, ".sel"},    {3'd0, bus.reg_sel},  {3'd0, e.sel});
            chk({tag, ".regWE"},  {7'd0, bus.regWE},    {7'd0, e.regwe});
            chk({tag, ".memWE"},  {7'd0, bus.memWE},    {7'd0, e.memwe});
            chk({tag, ".brnch"},  {7'd0, bus.brnch},    {7'd0, e.brnch});
            chk({tag, ".lw"},     {7'd0, bus.lw},       {7'd0, e.lw});
            chk({tag, ".mem_sc"}, {7'd0, bus.mem_sc},   {7'd0, e.mem_sc});
        end
        $display("txn %-10s instr=%h reg_data=%h reset=%b acc=%h alu=%h z=%b c=%b",
                 tag, ins, rd, rst, bus.acc_out, bus.alu_out, bus.alu_zero, bus.alu_carry);
        @(posedge clk);
        if (rst)                   model_acc = 8'h00;
        else if (ins[7:5] == 3'd0) model_acc = {{3{ins[4]}}, ins[4:0]};
        else if (ins[7:5] == 3'd1) model_acc = rd;
        #1;
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.instr    = 8'h1F;
        bus.reg_data = 8'h00;
        @(posedge clk);
        #1;
        model_acc = 8'h00;

        // Reset held with LI -1: accumulator stays 0, strobes masked
        step(8'h1F, 8'h00, 1'b1, "rst0");
        step(8'h1F, 8'h00, 1'b1, "rst1");
        chk("rst.acc", bus.acc_out, 8'h00);
        step(8'h1F, 8'h00, 1'b0, "li_m1");
        chk("li_m1.acc", bus.acc_out, 8'hFF);

        // Sign extension of the immediate
        step(8'h0F, 8'h00, 1'b0, "li_0f");
        chk("li_0f.acc", bus.acc_out, 8'h0F);
        step(8'h10, 8'h00, 1'b0, "li_10");
        chk("li_10.acc", bus.acc_out, 8'hF0);

        // ADD with carry out
        step(8'h63, 8'h20, 1'b0, "add_c");
        chk("add_c.alu",   bus.alu_out, 8'h10);
        chk("add_c.carry", {7'd0, bus.alu_carry}, 8'h01);
        chk("add_c.sel",   {3'd0, bus.reg_sel}, 8'h03);

        // SUB to zero, then a borrow
        step(8'h05, 8'h00, 1'b0, "li_05");
        step(8'h81, 8'h05, 1'b0, "sub_z");
        chk("sub_z.zero", {7'd0, bus.alu_zero}, 8'h01);
        step(8'h81, 8'h06, 1'b0, "sub_b");
        chk("sub_b.alu",   bus.alu_out, 8'hFF);
        chk("sub_b.carry", {7'd0, bus.alu_carry}, 8'h00);

        // Memory and branch strobes leave the accumulator alone
        step(8'hC2, 8'h99, 1'b0, "lw");
        step(8'hE2, 8'h99, 1'b0, "sw");
        step(8'hA4, 8'h99, 1'b0, "jr");
        chk("jr.acc", bus.acc_out, 8'h05);

        // LA then MV
        step(8'h27, 8'h3C, 1'b0, "la");
        chk("la.acc", bus.acc_out, 8'h3C);
        step(8'h48, 8'h00, 1'b0, "mv");
        chk("mv.alu", bus.alu_out, 8'h3C);

        // Reset wins over an executing LI / LA; strobes masked under reset
        step(8'h0A, 8'h00, 1'b0, "li_0a");
        step(8'h0B, 8'h00, 1'b1, "rst_li");
        chk("rst_li.acc", bus.acc_out, 8'h00);
        step(8'hE1, 8'h55, 1'b1, "rst_sw");
        step(8'hA1, 8'h55, 1'b1, "rst_jr");
        step(8'h21, 8'h77, 1'b1, "rst_la");
        step(8'h21, 8'h77, 1'b0, "la_77");
        chk("la_77.acc", bus.acc_out, 8'h77);

        // Mixed instruction stream
        for (int i = 0; i < 40; i++) begin
            step(8'($urandom), 8'($urandom), 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
